// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// mult/multu/div/divu run for a fixed number of busy cycles and then
// commit their 64-bit result to {HI,LO}. mthi/mtlo write while idle.
// Optional feature macro MD_UNIT_MADD_EN adds madd/maddu/msub/msubu
// (md_op 7..10), which accumulate into {HI,LO} with mult latency.
//
// state | meaning
// IDLE  | no operation pending, busy=0, mthi/mtlo accepted
// RUN   | result latched, counting down, busy=1
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [63:0]    tmp, tmp_n;
    logic           wr_pend, wr_pend_n;
    logic [31:0]    hi_n, lo_n;

    logic [63:0]    prod_s, prod_u, result;
    logic [31:0]    a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0]    q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic           op_valid, op_div, op_wr;

    // Arithmetic datapath and opcode decode; the result is captured at the start edge.
    always_comb begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u   = {32'd0, A} * {32'd0, B};
        // Signed divide on magnitudes avoids the INT_MIN / -1 overflow case:
        // 0x80000000 / 1 gives 0x80000000 with remainder 0, which is the wanted answer.
        a_mag    = A[31] ? (~A + 32'd1) : A;
        b_mag    = B[31] ? (~B + 32'd1) : B;
        b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_nz     = (B == 32'd0) ? 32'd1 : B;
        q_mag    = a_mag / b_mag_nz;
        r_mag    = a_mag % b_mag_nz;
        q_s      = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s      = A[31] ? (~r_mag + 32'd1) : r_mag;
        q_u      = A / b_nz;
        r_u      = A % b_nz;

        op_valid = 1'b0;
        op_div   = 1'b0;
        op_wr    = 1'b1;
        result   = 64'd0;
        case (md_op)
            4'd1: begin op_valid = 1'b1; result = prod_s; end
            4'd2: begin op_valid = 1'b1; result = prod_u; end
            4'd3: begin
                op_valid = 1'b1; op_div = 1'b1;
                op_wr    = (B != 32'd0);
                result   = {r_s, q_s};
            end
            4'd4: begin
                op_valid = 1'b1; op_div = 1'b1;
                op_wr    = (B != 32'd0);
                result   = {r_u, q_u};
            end
`ifdef MD_UNIT_MADD_EN
            4'd7:  begin op_valid = 1'b1; result = {HI, LO} + prod_s; end
            4'd8:  begin op_valid = 1'b1; result = {HI, LO} + prod_u; end
            4'd9:  begin op_valid = 1'b1; result = {HI, LO} - prod_s; end
            4'd10: begin op_valid = 1'b1; result = {HI, LO} - prod_u; end
`endif
            default: ;
        endcase
    end

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tmp_n     = tmp;
        wr_pend_n = wr_pend;
        hi_n      = HI;
        lo_n      = LO;
        case (state)
            IDLE: begin
                // A flushed instruction (req) must leave no trace.
                if (!req) begin
                    if (start && op_valid) begin
                        tmp_n     = result;
                        wr_pend_n = op_wr;
                        cnt_n     = op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_n   = RUN;
                    end
                    if (md_op == 4'd5) hi_n = A;
                    if (md_op == 4'd6) lo_n = A;
                end
            end
            RUN: begin
                // Runs to completion regardless of req: it belongs to an older instruction.
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    if (wr_pend) {hi_n, lo_n} = tmp;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tmp     <= '0;
            wr_pend <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tmp     <= tmp_n;
            wr_pend <= wr_pend_n;
            HI      <= hi_n;
            LO      <= lo_n;
        end
    end

    assign busy = (state == RUN);

endmodule
